reduce_tree_pipe: RTL and testbench
===================================

// Module: reduce_tree_pipe
// PURPOSE
// Parametrised, pipelined bit-reduction tree (AND / OR / NOR / NAND of an N-bit word) with valid/ready flow control.
// Generalises the fixed 64-bit 4-ary reduction gates to any WIDTH and FAN_IN, with a pipeline register after every tree level.
// Used for the ALU zero flag (NOR), all-ones detect (AND) and forwarding/hazard match detect in the pipelined datapath.
// PARAMETERS
// WIDTH   64  input word width in bits, >= 2
// FAN_IN  4   inputs combined per tree node per level, >= 2
// LEVELS  derived localparam = ceil(log_FAN_IN(WIDTH)); 64/4 -> 3, 32/4 -> 3, 16/4 -> 2
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      asynchronous, active-high reset
// in_valid   in   1      in_data/in_op are valid this cycle
// in_ready   out  1      stage 0 can accept; a transfer happens when in_valid && in_ready
// in_data    in   WIDTH  word to reduce
// in_op      in   2      00 AND, 01 OR, 10 NOR, 11 NAND
// in_tag     in   4      opaque sideband carried alongside the word (e.g. pipeline slot id)
// out_valid  out  1      out_result/out_tag are valid
// out_ready  in   1      consumer accepts; a transfer happens when out_valid && out_ready
// out_result out  1      reduction result
// out_tag    out  4      in_tag of the same transaction
// BEHAVIOUR
// - One clock, asynchronous active-high reset. Reset clears every stage valid bit immediately.
//   out_valid=0, out_result=0, out_tag=0 while reset is high. Data registers need not be cleared.
// - Tree: level k combines groups of FAN_IN partial results from level k-1. The last group at a level may be short.
//   Missing inputs are padded with the identity: 1 for the AND class (op 00/11), 0 for the OR class (op 01/10).
// - Base op per node is AND for the AND class and OR for the OR class. Inversion (NOR/NAND) is applied only at the final level.
// - Stage k register holds: partial results, the op, the tag and valid_k. Stage LEVELS-1 drives the out_* ports.
// - Latency: LEVELS cycles from the input transfer to out_valid (64/4: accept at edge N, out_valid after edge N+2).
// - Throughput: 1 result per cycle while out_ready=1. Transactions stay in order; there is no reordering or drop.
// - Flow control per stage: ready_k = !valid_k || ready_{k+1}, with ready_LEVELS = out_ready. in_ready = ready_0.
//   Stage k loads when ready_k, and valid_k <= valid_{k-1} (in_valid for k=0).
// - Backpressure: with out_ready=0 the pipe fills. in_ready falls only when every stage holds valid data.
//   Held outputs stay stable (out_result, out_tag unchanged) until accepted.
// - Bubbles collapse: a stalled output with empty upstream stages keeps accepting new inputs until those stages fill.
// - Simultaneous input and output transfer when full with out_ready=1: both occur and occupancy is unchanged.
// - Reset mid-operation: all in-flight transactions are discarded, and no out_valid is seen after reset deasserts until new input arrives.
// - WIDTH <= FAN_IN gives LEVELS=1: a single registered stage with 1-cycle latency.
// - in_op is sampled only on an input transfer. Values on idle cycles are ignored.
// CONFIGURATION
// REDUCE_PARITY_EN defined: adds port out_parity (out, 1) = XOR of all in_data bits.
//   out_parity is computed in a parallel XOR tree with the same staging, latency and handshake as out_result, independent of in_op.
//   Reset value is 0.
// REDUCE_PARITY_EN undefined: no out_parity port and no XOR tree logic. All other behaviour is identical.
// TESTING
// 1 Reset: assert reset mid-stream with 3 in flight -> out_valid=0 at once, and no output after release without new input.
// 2 WIDTH=64, out_ready=1, op=NOR: data 0 -> result 1; data 64'h8000_0000_0000_0000 -> 0. Each arrives 3 cycles after accept.
// 3 op=AND: data all-ones -> 1, data 64'hFFFF_FFFF_FFFF_FFFE -> 0. op=NAND: all-ones -> 0.
//   op=OR: 64'h1 -> 1. Back-to-back, one result per cycle with tags 0..3 in order.
// 4 Backpressure: out_ready=0 and 5 inputs offered -> exactly 3 accepted, then in_ready=0 with out held stable.
//   Release out_ready -> tags delivered in order with no loss or duplication.
// 5 Odd size WIDTH=10, FAN_IN=4 (LEVELS=2): AND of 10'h3FF -> 1, NOR of 10'h200 -> 0. Verifies identity padding.
// 6 REDUCE_PARITY_EN: data 64'h7 -> out_parity 1, 64'h3 -> 0, aligned with out_result.
//   Randomised data and op checked against a reference model for WIDTH {8, 33, 64} and FAN_IN {2, 4}.

Source files
------------

// File: rtl/reduce_tree_pipe.sv
// Pipelined AND/OR/NOR/NAND reduction tree with a register after every level and valid/ready flow.
// Optional parallel XOR (parity) tree enabled by defining REDUCE_PARITY_EN.
module reduce_tree_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned FAN_IN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [3:0]       out_tag
`ifdef REDUCE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  // Number of partial results entering level lvl (level 0 sees the raw word).
  function automatic int unsigned nodes_in(int unsigned lvl);
    int unsigned n;
    n = WIDTH;
    for (int unsigned i = 0; i < lvl; i++) n = (n + FAN_IN - 1) / FAN_IN;
    return n;
  endfunction

  function automatic int unsigned calc_levels();
    int unsigned n;
    int unsigned l;
    n = WIDTH;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 1) begin
        n = (n + FAN_IN - 1) / FAN_IN;
        l++;
      end
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = calc_levels();

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NI = nodes_in(k);
    localparam int unsigned NO = nodes_in(k + 1);
    localparam int unsigned NP = NO * FAN_IN;

    logic [NI-1:0] src;
    logic [1:0]    op_in;
    logic [3:0]    tag_in;
    logic          valid_in;
    logic          rdy;
    logic          rdy_next;
    logic          is_and;
    logic [NP-1:0] pad;
    logic [NO-1:0] node;
    logic [NO-1:0] part_d, part_q;
    logic [3:0]    tag_d, tag_q;
    logic          valid_d, valid_q;

    if (k == 0) begin : g_first
      assign src      = in_data;
      assign op_in    = in_op;
      assign tag_in   = in_tag;
      assign valid_in = in_valid;
    end else begin : g_mid
      assign src      = g_lvl[k-1].part_q;
      assign op_in    = g_lvl[k-1].g_op.op_q;
      assign tag_in   = g_lvl[k-1].tag_q;
      assign valid_in = g_lvl[k-1].valid_q;
    end

    if (k == LEVELS - 1) begin : g_last
      assign rdy_next = out_ready;
    end else begin : g_next
      assign rdy_next = g_lvl[k+1].rdy;
    end

    assign rdy = !valid_q || rdy_next;

    // Short final group is padded with the identity of the base op so it never masks the result.
    always_comb begin
      is_and = (op_in == 2'b00) || (op_in == 2'b11);
      pad    = {NP{is_and}};
      for (int i = 0; i < NI; i++) pad[i] = src[i];
      node = '0;
      for (int j = 0; j < NO; j++) begin
        node[j] = is_and ? &pad[j*FAN_IN +: FAN_IN] : |pad[j*FAN_IN +: FAN_IN];
      end
      if (k == LEVELS - 1) node = node ^ {NO{op_in[1]}};
    end

    always_comb begin
      valid_d = valid_q;
      part_d  = part_q;
      tag_d   = tag_q;
      if (rdy) begin
        valid_d = valid_in;
        part_d  = node;
        tag_d   = tag_in;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        part_q  <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        part_q  <= part_d;
        tag_q   <= tag_d;
      end
    end

    // The last level has already applied the op, so it keeps no copy of it.
    if (k < LEVELS - 1) begin : g_op
      logic [1:0] op_d, op_q;

      always_comb begin
        op_d = op_q;
        if (rdy) op_d = op_in;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) op_q <= 2'b00;
        else       op_q <= op_d;
      end
    end

`ifdef REDUCE_PARITY_EN
    logic [NI-1:0] psrc;
    logic [NP-1:0] ppad;
    logic [NO-1:0] pnode;
    logic [NO-1:0] par_d, par_q;

    if (k == 0) begin : g_psrc_first
      assign psrc = in_data;
    end else begin : g_psrc_mid
      assign psrc = g_lvl[k-1].par_q;
    end

    always_comb begin
      ppad = '0;
      for (int i = 0; i < NI; i++) ppad[i] = psrc[i];
      pnode = '0;
      for (int j = 0; j < NO; j++) pnode[j] = ^ppad[j*FAN_IN +: FAN_IN];
      par_d = par_q;
      if (rdy) par_d = pnode;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= '0;
      else       par_q <= par_d;
    end
`endif
  end

  assign in_ready   = g_lvl[0].rdy;
  assign out_valid  = g_lvl[LEVELS-1].valid_q;
  assign out_result = g_lvl[LEVELS-1].part_q[0];
  assign out_tag    = g_lvl[LEVELS-1].tag_q;
`ifdef REDUCE_PARITY_EN
  assign out_parity = g_lvl[LEVELS-1].par_q[0];
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench for reduce_tree_pipe: a 64/4 instance under full handshake control plus a
// bank of sizes (8/33/64 x 2/4 and 10/4) fed with shared random stimulus.
module tb_reduce_tree_pipe;

  typedef struct packed {
    logic       res;
    logic [3:0] tag;
    logic       par;
  } exp_t;

  localparam int NCFG = 7;

  function automatic int cfg_w(input int g);
    case (g)
      0, 1:    return 8;
      2, 3:    return 33;
      4, 5:    return 64;
      default: return 10;
    endcase
  endfunction

  function automatic int cfg_f(input int g);
    case (g)
      0, 2, 4: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic exp_t model(input logic [63:0] d, input logic [1:0] op, input int w,
                                 input logic [3:0] tag);
    exp_t e;
    logic a, o, x;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < w; i++) begin
      a = a & d[i];
      o = o | d[i];
      x = x ^ d[i];
    end
    case (op)
      2'b00:   e.res = a;
      2'b01:   e.res = o;
      2'b10:   e.res = ~o;
      default: e.res = ~a;
    endcase
    e.tag = tag;
    e.par = x;
    return e;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_result;
  logic [3:0]  out_tag;
`ifdef REDUCE_PARITY_EN
  logic        out_parity;
`endif

  logic        r_valid = 1'b0;
  logic [63:0] r_data = '0;
  logic [1:0]  r_op = '0;
  logic [3:0]  r_tag = '0;
  logic        r_ready = 1'b1;
  logic [NCFG-1:0]   a_ov, a_res, a_ir;
  logic [NCFG*4-1:0] a_tag;
`ifdef REDUCE_PARITY_EN
  logic [NCFG-1:0]   a_par;
`endif

  int   vecs = 0;
  int   errs = 0;
  exp_t scb[$];
  exp_t aq[NCFG][$];

  always #5 clk = ~clk;

  reduce_tree_pipe #(.WIDTH(64), .FAN_IN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag)
`ifdef REDUCE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int F = cfg_f(g);
    reduce_tree_pipe #(.WIDTH(W), .FAN_IN(F)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (r_valid),
      .in_ready  (a_ir[g]),
      .in_data   (r_data[W-1:0]),
      .in_op     (r_op),
      .in_tag    (r_tag),
      .out_valid (a_ov[g]),
      .out_ready (r_ready),
      .out_result(a_res[g]),
      .out_tag   (a_tag[g*4 +: 4])
`ifdef REDUCE_PARITY_EN
      ,
      .out_parity(a_par[g])
`endif
    );
  end

  // Drive one offer on the 64/4 instance; record the expectation only if it will be taken.
  task automatic offer(input logic [63:0] d, input logic [1:0] op, input logic [3:0] tag,
                       output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_tag   = tag;
    #1;
    acc = in_ready;
    if (acc) scb.push_back(model(d, op, 64, tag));
  endtask

  task automatic test_reset();
    logic acc;
    logic seen;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0 || out_result !== 1'b0 || out_tag !== 4'h0) begin
      errs++;
      $display("FAIL reset_state: valid=%b result=%b tag=%h, required 0 0 0",
               out_valid, out_result, out_tag);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      offer(64'h0, 2'b10, 4'(i), acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++;
      $display("FAIL reset_prefill: out_valid=%b, required 1", out_valid);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || out_tag !== 4'h0 || out_result !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: valid=%b tag=%h result=%b, required 0 0 0",
               out_valid, out_tag, out_result);
    end
    scb.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL reset_no_ghost: out_valid seen=%b after reset, required 0", seen);
    end
  endtask

  task automatic test_nor_latency();
    logic [63:0] d[2];
    logic acc;
    int lat;
    exp_t e;
    d[0] = 64'h0;
    d[1] = 64'h8000_0000_0000_0000;
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      offer(d[v], 2'b10, 4'(v + 1), acc);
      lat = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
      end while (out_valid !== 1'b1 && lat < 10);
      vecs++;
      if (lat != 3) begin
        errs++;
        $display("FAIL nor_latency[%0d]: %0d cycles, required 3", v, lat);
      end
      vecs++;
      if (scb.size() == 0) begin
        errs++;
        $display("FAIL nor_result[%0d]: scoreboard empty, required one entry", v);
      end else begin
        e = scb.pop_front();
        if (out_result !== e.res || out_tag !== e.tag) begin
          errs++;
          $display("FAIL nor_result[%0d]: result=%b tag=%h, required %b %h",
                   v, out_result, out_tag, e.res, e.tag);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d[4];
    logic [1:0] op[4];
    logic acc;
    exp_t e;
    int got, first, last;
    d[0] = '1;                     op[0] = 2'b00;
    d[1] = 64'hFFFF_FFFF_FFFF_FFFE; op[1] = 2'b00;
    d[2] = '1;                     op[2] = 2'b11;
    d[3] = 64'h1;                  op[3] = 2'b01;
    out_ready = 1'b1;
    got = 0;
    first = -1;
    last = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        vecs++;
        if (scb.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra: unexpected output tag=%h", out_tag);
        end else begin
          e = scb.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            errs++;
            $display("FAIL b2b_result: result=%b tag=%h, required %b %h",
                     out_result, out_tag, e.res, e.tag);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (cyc < 4) offer(d[cyc], op[cyc], 4'(cyc), acc);
      else in_valid = 1'b0;
    end
    vecs++;
    if (got != 4 || last - first != 3) begin
      errs++;
      $display("FAIL b2b_rate: %0d results over %0d cycles, required 4 over 3",
               got, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d[5];
    logic [1:0] op[5];
    logic acc, held, stable;
    logic hres;
    logic [3:0] htag;
    exp_t e;
    int sent, got, cyc;
    for (int i = 0; i < 5; i++) begin
      d[i]  = {$urandom, $urandom};
      op[i] = 2'($urandom_range(0, 3));
    end
    d[1] = '1;
    op[1] = 2'b00;
    out_ready = 1'b0;
    sent = 0;
    held = 1'b0;
    stable = 1'b1;
    hres = 1'b0;
    htag = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!held) begin
          hres = out_result;
          htag = out_tag;
          held = 1'b1;
        end else if (out_result !== hres || out_tag !== htag) begin
          stable = 1'b0;
        end
      end
      offer(d[sent], op[sent], 4'(sent + 4), acc);
      if (acc) sent++;
    end
    vecs++;
    if (sent != 3) begin
      errs++;
      $display("FAIL bp_accepted: %0d accepted under stall, required 3", sent);
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_in_ready: in_ready=%b when full, required 0", in_ready);
    end
    vecs++;
    if (!held || !stable) begin
      errs++;
      $display("FAIL bp_hold: held=%b stable=%b, required 1 1", held, stable);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_full_passthru: in_ready=%b when full and out_ready, required 1", in_ready);
    end
    got = 0;
    cyc = 0;
    while (cyc < 20 && !(sent == 5 && scb.size() == 0)) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        vecs++;
        if (scb.size() == 0) begin
          errs++;
          $display("FAIL bp_dup: unexpected output tag=%h", out_tag);
        end else begin
          e = scb.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            errs++;
            $display("FAIL bp_order: result=%b tag=%h, required %b %h",
                     out_result, out_tag, e.res, e.tag);
          end
        end
        got++;
      end
      if (sent < 5) begin
        offer(d[sent], op[sent], 4'(sent + 4), acc);
        if (acc) sent++;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    vecs++;
    if (got != 5 || scb.size() != 0) begin
      errs++;
      $display("FAIL bp_drain: %0d delivered, %0d pending, required 5 and 0", got, scb.size());
    end
  endtask

`ifdef REDUCE_PARITY_EN
  task automatic test_parity();
    logic [63:0] d[2];
    logic acc;
    exp_t e;
    int got;
    d[0] = 64'h7;
    d[1] = 64'h3;
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        vecs++;
        if (scb.size() == 0) begin
          errs++;
          $display("FAIL parity_extra: unexpected output tag=%h", out_tag);
        end else begin
          e = scb.pop_front();
          if (out_parity !== e.par || out_result !== e.res || out_tag !== e.tag) begin
            errs++;
            $display("FAIL parity: par=%b result=%b tag=%h, required %b %b %h",
                     out_parity, out_result, out_tag, e.par, e.res, e.tag);
          end
        end
        got++;
      end
      if (cyc < 2) offer(d[cyc], 2'b01, 4'(cyc + 9), acc);
      else in_valid = 1'b0;
    end
    vecs++;
    if (got != 2) begin
      errs++;
      $display("FAIL parity_count: %0d results, required 2", got);
    end
  endtask
`endif

  task automatic test_odd_size();
    logic [63:0] d[3];
    logic [1:0] op[3];
    logic res[3];
    logic par[3];
    exp_t e;
    int got;
    d[0] = 64'h3FF; op[0] = 2'b00; res[0] = 1'b1; par[0] = 1'b0;
    d[1] = 64'h200; op[1] = 2'b10; res[1] = 1'b0; par[1] = 1'b1;
    d[2] = 64'h0;   op[2] = 2'b10; res[2] = 1'b1; par[2] = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (a_ov[6] === 1'b1) begin
        vecs++;
        if (aq[6].size() == 0) begin
          errs++;
          $display("FAIL odd_extra: unexpected output tag=%h", a_tag[24 +: 4]);
        end else begin
          e = aq[6].pop_front();
          if (a_res[6] !== e.res || a_tag[24 +: 4] !== e.tag) begin
            errs++;
            $display("FAIL odd_result: result=%b tag=%h, required %b %h",
                     a_res[6], a_tag[24 +: 4], e.res, e.tag);
          end
`ifdef REDUCE_PARITY_EN
          if (a_par[6] !== e.par) begin
            errs++;
            $display("FAIL odd_parity: par=%b, required %b", a_par[6], e.par);
          end
`endif
        end
        got++;
      end
      r_valid = (cyc < 3);
      if (cyc < 3) begin
        r_data = d[cyc];
        r_op   = op[cyc];
        r_tag  = 4'(cyc + 1);
      end
      #1;
      if (cyc < 3 && a_ir[6]) begin
        e.res = res[cyc];
        e.tag = 4'(cyc + 1);
        e.par = par[cyc];
        aq[6].push_back(e);
      end
    end
    r_valid = 1'b0;
    vecs++;
    if (got != 3 || aq[6].size() != 0) begin
      errs++;
      $display("FAIL odd_count: %0d results, %0d pending, required 3 and 0", got, aq[6].size());
    end
  endtask

  task automatic test_random_configs();
    exp_t e;
    int kind;
    for (int g = 0; g < NCFG; g++) aq[g].delete();
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        if (a_ov[g] === 1'b1) begin
          vecs++;
          if (aq[g].size() == 0) begin
            errs++;
            $display("FAIL rand_extra[cfg%0d]: unexpected output tag=%h", g, a_tag[g*4 +: 4]);
          end else begin
            e = aq[g].pop_front();
            if (a_res[g] !== e.res || a_tag[g*4 +: 4] !== e.tag) begin
              errs++;
              $display("FAIL rand_result[cfg%0d]: result=%b tag=%h, required %b %h",
                       g, a_res[g], a_tag[g*4 +: 4], e.res, e.tag);
            end
`ifdef REDUCE_PARITY_EN
            if (a_par[g] !== e.par) begin
              errs++;
              $display("FAIL rand_parity[cfg%0d]: par=%b, required %b", g, a_par[g], e.par);
            end
`endif
          end
        end
      end
      r_valid = (cyc < 88) && ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       r_data = {$urandom, $urandom};
        1:       r_data = '1;
        2:       r_data = '0;
        default: r_data = 64'h1 << $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 1) == 1 && kind == 1) r_data[$urandom_range(0, 9)] = 1'b0;
      r_op  = 2'($urandom_range(0, 3));
      r_tag = 4'(cyc);
      #1;
      if (r_valid) begin
        for (int g = 0; g < NCFG; g++) begin
          if (a_ir[g]) aq[g].push_back(model(r_data, r_op, cfg_w(g), r_tag));
        end
      end
    end
    r_valid = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      vecs++;
      if (aq[g].size() != 0) begin
        errs++;
        $display("FAIL rand_drain[cfg%0d]: %0d pending, required 0", g, aq[g].size());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nor_latency();
    test_back_to_back();
    test_backpressure();
`ifdef REDUCE_PARITY_EN
    test_parity();
`endif
    test_odd_size();
    test_random_configs();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
